// File: rtl/data_cache.sv
// Direct-mapped, write-back data cache with a 4-byte block and a
// READ/WRITE/BUSYWAIT handshake on both the CPU and the memory side.
//
// state     | meaning
// IDLE      | serving hits; a miss picks WRITEBACK (dirty victim) or FETCH
// WRITEBACK | pushing the dirty victim block to memory
// FETCH     | reading the requested block from memory
// UPDATE    | installing the fetched block, line becomes valid and clean
module data_cache #(
    parameter int INDEX_BITS = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 6 - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        UPDATE    = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [31:0]         data_q  [LINES];
    logic [TAG_BITS-1:0] tag_q   [LINES];
    logic [LINES-1:0]    valid_q;
    logic [LINES-1:0]    dirty_q;

    logic [TAG_BITS-1:0]   tag;
    logic [INDEX_BITS-1:0] idx;
    logic [1:0]            off;
    logic [31:0]           line;
    logic                  req;
    logic                  hit;
    logic                  wr_hit;

    assign tag    = ADDRESS[7:2+INDEX_BITS];
    assign idx    = ADDRESS[1+INDEX_BITS:2];
    assign off    = ADDRESS[1:0];
    assign line   = data_q[idx];
    assign req    = READ | WRITE;
    assign hit    = valid_q[idx] & (tag_q[idx] == tag);
    // A simultaneous READ and WRITE is resolved as a store.
    assign wr_hit = (state_q == IDLE) & WRITE & hit;

    assign READDATA = hit ? line[{off, 3'b000} +: 8] : 8'h00;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        BUSYWAIT      = 1'b0;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = 6'd0;
        MEM_WRITEDATA = 32'd0;
        case (state_q)
            IDLE: begin
                BUSYWAIT = req & ~hit;
                if (req && !hit) begin
                    state_d = dirty_q[idx] ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: begin
                BUSYWAIT      = 1'b1;
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {tag_q[idx], idx};
                MEM_WRITEDATA = line;
                if (!MEM_BUSYWAIT) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                BUSYWAIT    = 1'b1;
                MEM_READ    = 1'b1;
                MEM_ADDRESS = {tag, idx};
                if (!MEM_BUSYWAIT) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                BUSYWAIT = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // No stall is claimed while the cache is being held in reset.
        if (RESET) begin
            BUSYWAIT = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (state_q == UPDATE) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (wr_hit) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Payload needs no reset: valid gates every use, and an async reset
    // forces state_q out of UPDATE so an aborted miss writes nothing.
    always_ff @(posedge CLK) begin
        if (state_q == UPDATE) begin
            data_q[idx] <= MEM_READDATA;
            tag_q[idx]  <= tag;
        end else if (wr_hit) begin
            data_q[idx][{off, 3'b000} +: 8] <= WRITEDATA;
        end
    end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-back, byte-addressed data cache.
- Sits between the CPU control/datapath and data memory.
- Responds to the CPU's READ/WRITE strobes with BUSYWAIT, which the control unit uses to drop READ/WRITE on its falling edge.
- On a miss it writes back a dirty victim and fetches a 4-byte block from main memory over a second READ/WRITE/BUSYWAIT handshake, in which the cache is the initiator.

Parameters:
- INDEX_BITS, 3, number of set-index bits. Lines = 2^INDEX_BITS. Tag width = 6-INDEX_BITS. Offset fixed at 2 bits (4-byte block).

Ports:
- CLK  input  1  system clock, posedge active
- RESET  input  1  asynchronous, active-high reset
- READ  input  1  CPU load request
- WRITE  input  1  CPU store request
- ADDRESS  input  8  CPU byte address {tag, index, offset}
- WRITEDATA  input  8  CPU store byte
- READDATA  output  8  CPU load byte
- BUSYWAIT  output  1  stall to CPU; high while the request is unresolved
- MEM_READ  output  1  block fetch request to main memory
- MEM_WRITE  output  1  block write-back request to main memory
- MEM_ADDRESS  output  6  block address {tag, index}
- MEM_WRITEDATA  output  32  victim block, byte0 in [7:0]
- MEM_READDATA  input  32  fetched block, byte0 in [7:0]
- MEM_BUSYWAIT  input  1  main memory busy

Behaviour:
- Storage per line: 32-bit data, tag, valid, dirty.
- Reset (async): all valid=0, dirty=0, state=IDLE, MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0, BUSYWAIT=0, READDATA=0.
- Reset mid-miss aborts the transaction. Memory strobes drop immediately. No line is updated.
- hit = valid[idx] & (tag[idx]==ADDRESS tag), evaluated combinationally.
- Hit path:
  - READ and WRITE both high is illegal. The cache treats it as WRITE.
  - Read hit: READDATA = selected byte, combinationally. BUSYWAIT stays 0; zero stall.
  - Write hit: BUSYWAIT=0. At the next posedge the byte is written and dirty=1.
- BUSYWAIT = (READ|WRITE) & ~hit while in IDLE. BUSYWAIT = 1 in every other state.
- FSM states and transitions:
  - IDLE: on (READ|WRITE) & ~hit, go to WRITEBACK if dirty[idx], else FETCH. Otherwise stay.
  - WRITEBACK: MEM_WRITE=1, MEM_ADDRESS={tag[idx], idx}, MEM_WRITEDATA=data[idx]. Hold until a posedge with MEM_BUSYWAIT=0, then go to FETCH.
  - FETCH: MEM_READ=1, MEM_ADDRESS={ADDRESS tag, idx}. Hold until a posedge with MEM_BUSYWAIT=0, then go to UPDATE.
  - UPDATE: MEM strobes=0. At the posedge, data[idx]=MEM_READDATA, tag updated, valid=1, dirty=0. Go to IDLE.
- After UPDATE the re-evaluated request hits. Read: BUSYWAIT falls combinationally. Write: BUSYWAIT falls and the store completes at the following posedge.
- MEM_READ/MEM_WRITE deassert in the state after memory releases. They are never asserted together.
- The memory handshake tolerates MEM_BUSYWAIT already low at the first sampled edge, giving a 1-cycle transfer.
- CPU ADDRESS/WRITEDATA must stay stable while BUSYWAIT=1. The cache does not latch them.
- Miss latency: clean miss = FETCH cycles + 1 (UPDATE) + 0. Dirty miss adds the WRITEBACK cycles.
- Lines fill only on misses; there is no prefetch. Wrap-around: index is ADDRESS[4:2] with tag ADDRESS[7:5]. Addresses 0x04 and 0x24 conflict on the same line.

Test Plan:
- Cold read: RESET, READ addr 0x05, memory returns 0xDDCCBBAA after 5 cycles -> BUSYWAIT high, MEM_READ=1 with MEM_ADDRESS=0x01, line filled, READDATA=0xBB, BUSYWAIT low, no MEM_WRITE.
- Read hit: READ 0x06 next -> READDATA=0xCC same cycle, BUSYWAIT never rises, no memory strobes.
- Write hit: WRITE 0x07 data 0x5A -> no stall, line1 dirty=1, byte3=0x5A. Read 0x07 -> 0x5A.
- Dirty eviction: READ 0x25 (same index, tag 1) -> MEM_WRITE with MEM_ADDRESS=0x01 and MEM_WRITEDATA=0x5ACCBBAA first, then MEM_READ with MEM_ADDRESS=0x09, then hit.
- Reset mid-fetch: assert RESET during FETCH -> MEM_READ=0 and BUSYWAIT=0 immediately. A subsequent READ 0x05 misses because the line is invalid.
- Zero-wait memory: MEM_BUSYWAIT held 0 -> clean miss resolves in 2 cycles (FETCH, UPDATE).
